multicycle_control: RTL and testbench
=====================================

// Module: multicycle_control
// PURPOSE
//  Main control FSM for the ARMv8 multicycle datapath, the successor of the single-cycle CPU.
//  Sequences a shared instruction/data memory, IR, register file, ALU and PC over several states per instruction.
//  Waits on a memory ready handshake. Sits beside the datapath in the top level and drives every datapath control line.
// PARAMETERS
//  OPCODE_W  11  width of instruction opcode field inst[31:21]
//  CNT_W     32  width of performance counters (see CONFIGURATION)
// PORTS
//  clock          in   1        system clock, all state updates on rising edge
//  reset          in   1        synchronous, active-high; sampled on rising edge of clock
//  opcode         in   OPCODE_W IR[31:21], valid from DECODE onward
//  zero           in   1        ALU zero flag, same cycle
//  mem_ready      in   1        memory completes the current read/write this cycle
//  pc_write       out  1        unconditional PC load
//  pc_write_cond  out  1        PC load if zero==1
//  pc_src         out  1        0: ALU result, 1: ALUOut register
//  ir_write       out  1        IR load
//  i_or_d         out  1        memory address: 0 = PC, 1 = ALUOut
//  mem_read       out  1        memory read request
//  mem_write      out  1        memory write request
//  mem_to_reg     out  1        regfile write data: 0 = ALUOut, 1 = MDR
//  reg_write      out  1        regfile write enable
//  reg2loc        out  1        read port 2 address: 0 = Rm, 1 = Rt
//  alu_src_a      out  1        0 = PC, 1 = reg A
//  alu_src_b      out  2        00 = reg B, 01 = const 4, 10 = sign-ext imm, 11 = sign-ext imm<<2
//  alu_op         out  2        00 add, 01 pass B, 10 funct from opcode
//  illegal        out  1        unknown opcode trapped
//  state          out  4        current state encoding, for debug
//  cycle_cnt      out  CNT_W    cycles since reset
//  retired_cnt    out  CNT_W    completed instructions
// BEHAVIOUR
//  - Control outputs are a Moore decode of state, except the mem_ready gating listed below.
//    Unlisted outputs are 0. While reset=1 all outputs are 0; the FSM enters FETCH on that edge.
//  - reg2loc is 1 iff opcode is STUR or CBZ, in every state.
//  Opcodes:
//    LDUR 11111000010; STUR 11111000000; ADD 10001011000; SUB 11001011000;
//    AND 10001010000; ORR 10101010000; CBZ 10110100xxx; B 000101xxxxx.
//  States (encoding):
//    FETCH 0: mem_read=1, i_or_d=0, alu_src_b=01, alu_op=00.
//      If mem_ready: ir_write=1, pc_write=1, pc_src=0, go DECODE; else stay.
//    DECODE 1: alu_src_a=0, alu_src_b=11, alu_op=00 (branch target into ALUOut). Transitions:
//      LDUR/STUR -> MEM_ADDR; R-type -> EXEC_R; CBZ -> BR_CBZ; B -> BR_B; other -> ILLEGAL.
//    MEM_ADDR 2: alu_src_a=1, alu_src_b=10, alu_op=00. Transitions: LDUR -> MEM_RD; STUR -> MEM_WR.
//    MEM_RD 3: mem_read=1, i_or_d=1. mem_ready -> MEM_WB, else stay.
//    MEM_WB 4: reg_write=1, mem_to_reg=1 -> FETCH.
//    MEM_WR 5: mem_write=1, i_or_d=1. mem_ready -> FETCH, else stay.
//    EXEC_R 6: alu_src_a=1, alu_src_b=00, alu_op=10 -> R_WB.
//    R_WB 7: reg_write=1, mem_to_reg=0 -> FETCH.
//    BR_CBZ 8: alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond=1, pc_src=1 -> FETCH.
//    BR_B 9: pc_write=1, pc_src=1 -> FETCH.
//    ILLEGAL 15: illegal=1, all other outputs 0; stays until reset.
//  - Latency with zero-wait memory (mem_ready=1 at request):
//    LDUR 5, STUR 4, R-type 4, CBZ 3, B 3 cycles. Each wait cycle adds 1.
//  - Memory handshake: mem_read/mem_write stay asserted, address stable, until the cycle mem_ready=1.
//    mem_ready outside FETCH/MEM_RD/MEM_WR is ignored.
//  - Reset mid-instruction: abandons it, no write-back. Next state is FETCH and counters clear.
//  - Unused state encodings 10-14 -> ILLEGAL.
// CONFIGURATION
//  PERF_COUNTERS_EN defined:
//    cycle_cnt increments every non-reset cycle.
//    retired_cnt increments on the exit edge of MEM_WB, MEM_WR (mem_ready), R_WB, BR_CBZ and BR_B.
//    Both wrap modulo 2^CNT_W, are frozen in ILLEGAL and are 0 on reset.
//  Not defined: counter ports present but tied to 0, no counter flops.
// TESTING
//  - Reset held 2 cycles, mem_ready=1: all outputs 0 during reset; state=0, mem_read=1 on first cycle after.
//  - ADD (10001011000), mem_ready=1:
//    state 0,1,6,7,0; reg_write=1 only in state 7; alu_op=10 in state 6; retired_cnt=1.
//  - LDUR, mem_ready low 3 cycles in MEM_RD: mem_read, i_or_d held 4 cycles; reg_write, mem_to_reg in cycle 8.
//  - CBZ with zero=1, then zero=0: pc_write_cond=1, pc_src=1 in state 8 for both; reg2loc=1 throughout.
//  - Opcode 11111111111: illegal=1 from cycle 3 and stays; counters frozen; reset recovers to FETCH.
//  - Reset asserted in MEM_WR while mem_ready=0: mem_write drops that cycle; FETCH next; retired_cnt=0.

Source files
------------

// File: rtl/multicycle_control.sv
// Main control FSM for the ARMv8 multicycle datapath: sequences fetch, decode, memory, ALU and PC.
// Define PERF_COUNTERS_EN to build the cycle/retired counters; otherwise those ports read 0.
module multicycle_control #(
  parameter int OPCODE_W = 11,
  parameter int CNT_W    = 32
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                zero,
  input  logic                mem_ready,
  output logic                pc_write,
  output logic                pc_write_cond,
  output logic                pc_src,
  output logic                ir_write,
  output logic                i_or_d,
  output logic                mem_read,
  output logic                mem_write,
  output logic                mem_to_reg,
  output logic                reg_write,
  output logic                reg2loc,
  output logic                alu_src_a,
  output logic [1:0]          alu_src_b,
  output logic [1:0]          alu_op,
  output logic                illegal,
  output logic [3:0]          state,
  output logic [CNT_W-1:0]    cycle_cnt,
  output logic [CNT_W-1:0]    retired_cnt
);
  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEM_ADDR = 4'd2,
    MEM_RD   = 4'd3,
    MEM_WB   = 4'd4,
    MEM_WR   = 4'd5,
    EXEC_R   = 4'd6,
    R_WB     = 4'd7,
    BR_CBZ   = 4'd8,
    BR_B     = 4'd9,
    ILLEGAL  = 4'd15
  } state_t;

  localparam logic [OPCODE_W-1:0] OP_LDUR = 11'b11111000010;
  localparam logic [OPCODE_W-1:0] OP_STUR = 11'b11111000000;
  localparam logic [OPCODE_W-1:0] OP_ADD  = 11'b10001011000;
  localparam logic [OPCODE_W-1:0] OP_SUB  = 11'b11001011000;
  localparam logic [OPCODE_W-1:0] OP_AND  = 11'b10001010000;
  localparam logic [OPCODE_W-1:0] OP_ORR  = 11'b10101010000;

  state_t st;
  logic   is_ldur, is_stur, is_rtype, is_cbz, is_b;

  assign is_ldur  = (opcode == OP_LDUR);
  assign is_stur  = (opcode == OP_STUR);
  assign is_rtype = (opcode == OP_ADD) || (opcode == OP_SUB) ||
                    (opcode == OP_AND) || (opcode == OP_ORR);
  assign is_cbz   = (opcode[OPCODE_W-1 -: 8] == 8'b10110100);
  assign is_b     = (opcode[OPCODE_W-1 -: 6] == 6'b000101);

  // The branch decision on zero is made in the datapath through pc_write_cond.
  logic unused_zero;
  assign unused_zero = zero;

  always_ff @(posedge clock) begin
    if (reset) begin
      st <= FETCH;
    end else begin
      case (st)
        FETCH:    if (mem_ready) st <= DECODE;
        DECODE: begin
          if (is_ldur || is_stur) st <= MEM_ADDR;
          else if (is_rtype)      st <= EXEC_R;
          else if (is_cbz)        st <= BR_CBZ;
          else if (is_b)          st <= BR_B;
          else                    st <= ILLEGAL;
        end
        MEM_ADDR: begin
          if (is_ldur)      st <= MEM_RD;
          else if (is_stur) st <= MEM_WR;
          else              st <= ILLEGAL;
        end
        MEM_RD:   if (mem_ready) st <= MEM_WB;
        MEM_WB:   st <= FETCH;
        MEM_WR:   if (mem_ready) st <= FETCH;
        EXEC_R:   st <= R_WB;
        R_WB:     st <= FETCH;
        BR_CBZ:   st <= FETCH;
        BR_B:     st <= FETCH;
        ILLEGAL:  st <= ILLEGAL;
        default:  st <= ILLEGAL;
      endcase
    end
  end

  // Moore decode of st; only the FETCH IR/PC loads look at mem_ready. Reset forces everything low.
  always_comb begin
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    pc_src        = 1'b0;
    ir_write      = 1'b0;
    i_or_d        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    mem_to_reg    = 1'b0;
    reg_write     = 1'b0;
    reg2loc       = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    alu_op        = 2'b00;
    illegal       = 1'b0;
    state         = 4'd0;
    if (!reset) begin
      state   = st;
      reg2loc = (is_stur || is_cbz) && (st != ILLEGAL);
      case (st)
        FETCH: begin
          mem_read  = 1'b1;
          alu_src_b = 2'b01;
          ir_write  = mem_ready;
          pc_write  = mem_ready;
        end
        DECODE:   alu_src_b = 2'b11;
        MEM_ADDR: begin
          alu_src_a = 1'b1;
          alu_src_b = 2'b10;
        end
        MEM_RD: begin
          mem_read = 1'b1;
          i_or_d   = 1'b1;
        end
        MEM_WB: begin
          reg_write  = 1'b1;
          mem_to_reg = 1'b1;
        end
        MEM_WR: begin
          mem_write = 1'b1;
          i_or_d    = 1'b1;
        end
        EXEC_R: begin
          alu_src_a = 1'b1;
          alu_op    = 2'b10;
        end
        R_WB:     reg_write = 1'b1;
        BR_CBZ: begin
          alu_src_a     = 1'b1;
          alu_op        = 2'b01;
          pc_write_cond = 1'b1;
          pc_src        = 1'b1;
        end
        BR_B: begin
          pc_write = 1'b1;
          pc_src   = 1'b1;
        end
        ILLEGAL:  illegal = 1'b1;
        default:  ;
      endcase
    end
  end

`ifdef PERF_COUNTERS_EN
  logic [CNT_W-1:0] cyc_q, ret_q;
  logic             retire;

  assign retire = (st == MEM_WB) || (st == R_WB) || (st == BR_CBZ) || (st == BR_B) ||
                  ((st == MEM_WR) && mem_ready);

  always_ff @(posedge clock) begin
    if (reset) begin
      cyc_q <= '0;
      ret_q <= '0;
    end else if (st != ILLEGAL) begin
      cyc_q <= cyc_q + CNT_W'(1);
      if (retire) ret_q <= ret_q + CNT_W'(1);
    end
  end

  assign cycle_cnt   = reset ? '0 : cyc_q;
  assign retired_cnt = reset ? '0 : ret_q;
`else
  assign cycle_cnt   = '0;
  assign retired_cnt = '0;
`endif

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: directed cycle table, corner sequences, and random instruction
// streams expanded into expected per-cycle control words by an instruction-level model.
module tb_multicycle_control;
  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [10:0] opcode = '0;
  logic        zero = 1'b0;
  logic        mem_ready = 1'b0;
  logic        pc_write, pc_write_cond, pc_src, ir_write, i_or_d, mem_read, mem_write;
  logic        mem_to_reg, reg_write, reg2loc, alu_src_a, illegal;
  logic [1:0]  alu_src_b, alu_op;
  logic [3:0]  state;
  logic [31:0] cycle_cnt, retired_cnt;

  multicycle_control #(.OPCODE_W(11), .CNT_W(32)) dut (
    .clock(clock), .reset(reset), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .pc_src(pc_src), .ir_write(ir_write),
    .i_or_d(i_or_d), .mem_read(mem_read), .mem_write(mem_write), .mem_to_reg(mem_to_reg),
    .reg_write(reg_write), .reg2loc(reg2loc), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .alu_op(alu_op), .illegal(illegal), .state(state), .cycle_cnt(cycle_cnt),
    .retired_cnt(retired_cnt)
  );

  always #5 clock = ~clock;

  localparam logic [10:0] OP_LDUR = 11'b11111000010;
  localparam logic [10:0] OP_STUR = 11'b11111000000;
  localparam logic [10:0] OP_ADD  = 11'b10001011000;
  localparam logic [10:0] OP_SUB  = 11'b11001011000;
  localparam logic [10:0] OP_AND  = 11'b10001010000;
  localparam logic [10:0] OP_ORR  = 11'b10101010000;
  localparam logic [10:0] OP_CBZ1 = 11'b10110100101;
  localparam logic [10:0] OP_CBZ0 = 11'b10110100000;
  localparam logic [10:0] OP_B    = 11'b00010110011;
  localparam logic [10:0] OP_BAD  = 11'b11111111111;

  int checks = 0;
  int failures = 0;
  int exp_cyc = 0;
  int rret = 0;

`ifdef PERF_COUNTERS_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic [19:0] act_vec;
  assign act_vec = {state, pc_write, pc_write_cond, pc_src, ir_write, i_or_d, mem_read, mem_write,
                    mem_to_reg, reg_write, reg2loc, alu_src_a, alu_src_b, alu_op, illegal};

  function automatic bit r2l(input logic [10:0] op);
    return (op == OP_STUR) || (op[10:3] == 8'b10110100);
  endfunction

  // Expected control word for a phase, straight from the state table (ph < 0 means reset).
  function automatic logic [19:0] ctl(input int ph, input bit rdy, input bit rl);
    logic [3:0] s;
    bit pw, pwc, psrc, irw, iod, mr, mw, m2r, rw, asa, ill, r;
    logic [1:0] asb, aop;
    if (ph < 0) return '0;
    s = 4'(ph);
    {pw, pwc, psrc, irw, iod, mr, mw, m2r, rw, asa, ill} = '0;
    asb = 2'b00; aop = 2'b00;
    r = (ph == 15) ? 1'b0 : rl;
    case (ph)
      0:  begin mr = 1; asb = 2'b01; irw = rdy; pw = rdy; end
      1:  asb = 2'b11;
      2:  begin asa = 1; asb = 2'b10; end
      3:  begin mr = 1; iod = 1; end
      4:  begin rw = 1; m2r = 1; end
      5:  begin mw = 1; iod = 1; end
      6:  begin asa = 1; aop = 2'b10; end
      7:  rw = 1;
      8:  begin asa = 1; aop = 2'b01; pwc = 1; psrc = 1; end
      9:  begin pw = 1; psrc = 1; end
      15: ill = 1;
      default: ;
    endcase
    return {s, pw, pwc, psrc, irw, iod, mr, mw, m2r, rw, r, asa, asb, aop, ill};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // One clock: drive inputs, compare at the falling edge, advance past the rising edge.
  task automatic step(input bit rst, input logic [10:0] op, input bit rdy, input bit z,
                      input int ph, input int ret);
    reset = rst; opcode = op; mem_ready = rdy; zero = z;
    @(negedge clock);
    chk("ctl", 64'(act_vec), 64'(ctl(ph, rdy, r2l(op))));
    chk("cycle_cnt", 64'(cycle_cnt), (PERF && ph >= 0) ? 64'(exp_cyc) : 64'd0);
    chk("retired_cnt", 64'(retired_cnt), (PERF && ph >= 0) ? 64'(ret) : 64'd0);
    @(posedge clock); #1;
    if (rst) exp_cyc = 0;
    else if (ph != 15) exp_cyc++;
  endtask

  function automatic bit rb();
    return 1'($urandom);
  endfunction

  function automatic logic [10:0] gen_op(input int cls);
    logic [10:0] r;
    r = 11'($urandom);
    case (cls)
      0: return OP_LDUR;
      1: return OP_STUR;
      2: case (r[1:0]) 2'd0: return OP_ADD; 2'd1: return OP_SUB; 2'd2: return OP_AND; default: return OP_ORR; endcase
      3: return {8'b10110100, r[2:0]};
      default: return {6'b000101, r[4:0]};
    endcase
  endfunction

  // Instruction-level model: one instruction expands into its phases, waits and retirement.
  task automatic run_instr(input int cls, input int fw, input int mw);
    logic [10:0] op;
    op = gen_op(cls);
    for (int i = 0; i < fw; i++) step(0, op, 0, rb(), 0, rret);
    step(0, op, 1, rb(), 0, rret);
    step(0, op, rb(), rb(), 1, rret);
    case (cls)
      0: begin
        step(0, op, rb(), rb(), 2, rret);
        for (int i = 0; i < mw; i++) step(0, op, 0, rb(), 3, rret);
        step(0, op, 1, rb(), 3, rret);
        step(0, op, rb(), rb(), 4, rret);
      end
      1: begin
        step(0, op, rb(), rb(), 2, rret);
        for (int i = 0; i < mw; i++) step(0, op, 0, rb(), 5, rret);
        step(0, op, 1, rb(), 5, rret);
      end
      2: begin
        step(0, op, rb(), rb(), 6, rret);
        step(0, op, rb(), rb(), 7, rret);
      end
      3: step(0, op, rb(), rb(), 8, rret);
      default: step(0, op, rb(), rb(), 9, rret);
    endcase
    rret++;
  endtask

  typedef struct {
    bit          rst;
    logic [10:0] op;
    bit          rdy;
    bit          z;
    int          ph;
    int          ret;
  } vec_t;

  vec_t tbl[25];

  initial begin
    #1;
    tbl = '{
      '{1, OP_ADD,  1, 0, -1, 0}, '{1, OP_ADD,  1, 0, -1, 0},
      '{0, OP_ADD,  1, 0,  0, 0}, '{0, OP_ADD,  1, 0,  1, 0},
      '{0, OP_ADD,  0, 1,  6, 0}, '{0, OP_ADD,  1, 0,  7, 0},
      '{0, OP_LDUR, 1, 0,  0, 1}, '{0, OP_LDUR, 1, 0,  1, 1},
      '{0, OP_LDUR, 1, 0,  2, 1}, '{0, OP_LDUR, 0, 0,  3, 1},
      '{0, OP_LDUR, 0, 0,  3, 1}, '{0, OP_LDUR, 0, 0,  3, 1},
      '{0, OP_LDUR, 1, 0,  3, 1}, '{0, OP_LDUR, 0, 0,  4, 1},
      '{0, OP_CBZ1, 1, 1,  0, 2}, '{0, OP_CBZ1, 1, 1,  1, 2},
      '{0, OP_CBZ1, 1, 1,  8, 2}, '{0, OP_CBZ0, 1, 0,  0, 3},
      '{0, OP_CBZ0, 1, 0,  1, 3}, '{0, OP_CBZ0, 1, 0,  8, 3},
      '{0, OP_B,    0, 0,  0, 4}, '{0, OP_B,    1, 0,  0, 4},
      '{0, OP_B,    1, 0,  1, 4}, '{0, OP_B,    0, 0,  9, 4},
      '{0, OP_STUR, 1, 0,  0, 5}
    };
    for (int i = 0; i < 25; i++)
      step(tbl[i].rst, tbl[i].op, tbl[i].rdy, tbl[i].z, tbl[i].ph, tbl[i].ret);

    // Unknown opcode traps, freezes counters, and reset recovers.
    step(1, OP_BAD, 1, 0, -1, 0);
    step(0, OP_BAD, 1, 0, 0, 0);
    step(0, OP_BAD, 1, 0, 1, 0);
    for (int i = 0; i < 5; i++) step(0, OP_BAD, rb(), rb(), 15, 0);
    step(1, OP_BAD, 1, 0, -1, 0);
    step(0, OP_ADD, 1, 0, 0, 0);

    // Reset during a stalled store: write request drops at once, nothing retires.
    step(1, OP_STUR, 1, 0, -1, 0);
    step(0, OP_STUR, 1, 0, 0, 0);
    step(0, OP_STUR, 1, 0, 1, 0);
    step(0, OP_STUR, 1, 0, 2, 0);
    step(0, OP_STUR, 0, 0, 5, 0);
    step(0, OP_STUR, 0, 0, 5, 0);
    step(1, OP_STUR, 0, 0, -1, 0);
    step(0, OP_STUR, 0, 0, 0, 0);
    step(0, OP_STUR, 1, 0, 0, 0);

    // Random instruction stream with random fetch and memory wait states.
    step(1, OP_ADD, 0, 0, -1, 0);
    rret = 0;
    for (int n = 0; n < 200; n++)
      run_instr(int'($urandom_range(0, 4)), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
    step(0, OP_ADD, 0, 0, 0, rret);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
